// File: rtl/ifmap_decompressor.sv
// ifmap_decompressor
// Zero-run-length decoder feeding the ifmap buffer with dense packets.
// Each 64-bit compressed word holds TOKENS_PER_WORD 16-bit tokens
// {zero_run[15:8], value[7:0]}. A token expands to zero_run zeros and then
// one value. Exactly total_elements elements are emitted per layer, packed
// PACKET_SIZE at a time, and then done is raised.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, total_elements    layer start pulse and element count (sampled on start)
//   cmp_data/valid/ready     compressed word input handshake
//   global_buffer_req        consumer request
//   decompressor_ack         packet offered (== packet_valid)
//   decompressed_fifo_packet {data[PACKET_SIZE*ELEM_WIDTH-1:0], valid_mask[PACKET_SIZE-1:0], packet_valid}
//                            element k sits in data[8k+7:8k]; slots outside valid_mask read as 0
//   done                     all elements of the layer transferred
//   zero_count, token_count  performance counters
//
// Optional feature macro: DECOMP_PERF_CNT_EN builds the saturating performance
// counters; without it zero_count and token_count are tied to 0.

`ifndef IFMP_DATA_SIZE
`define IFMP_DATA_SIZE 8
`endif

module ifmap_decompressor #(
    parameter int TOKENS_PER_WORD = 4,
    parameter int PACKET_SIZE     = `IFMP_DATA_SIZE,
    parameter int ELEM_WIDTH      = 8,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [CNT_WIDTH-1:0]                      total_elements,
    input  logic [TOKENS_PER_WORD*16-1:0]             cmp_data,
    input  logic                                      cmp_valid,
    output logic                                      cmp_ready,
    input  logic                                      global_buffer_req,
    output logic                                      decompressor_ack,
    output logic [PACKET_SIZE*ELEM_WIDTH+PACKET_SIZE:0] decompressed_fifo_packet,
    output logic                                      done,
    output logic [31:0]                               zero_count,
    output logic [31:0]                               token_count
);

    localparam int TIDX_W = $clog2(TOKENS_PER_WORD);
    localparam int FILL_W = 5;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ZERO, S_VALUE, S_FLUSH, S_DONE} state_t;

    state_t                                   state_q;
    logic [TOKENS_PER_WORD*16-1:0]            word_q;
    logic [TIDX_W-1:0]                        tok_idx_q;
    logic [7:0]                               zeros_left_q;
    logic [CNT_WIDTH-1:0]                     remaining_q;
    logic [FILL_W-1:0]                        fill_q;
    logic [PACKET_SIZE-1:0][ELEM_WIDTH-1:0]   asm_q;
    logic [PACKET_SIZE*ELEM_WIDTH-1:0]        out_data_q;
    logic [PACKET_SIZE-1:0]                   out_mask_q;
    logic                                     out_valid_q;
    logic                                     done_q;

    // Current token fields and the run length of the following token
    logic [TIDX_W-1:0]     tok_nx;
    logic [7:0]            cur_run;
    logic [ELEM_WIDTH-1:0] cur_val;
    logic [7:0]            nxt_run;
    logic                  last_tok;

    assign tok_nx   = tok_idx_q + 1'b1;
    assign cur_run  = word_q[tok_idx_q*16+8 +: 8];
    assign cur_val  = word_q[tok_idx_q*16 +: ELEM_WIDTH];
    assign nxt_run  = word_q[tok_nx*16+8 +: 8];
    assign last_tok = (tok_idx_q == TIDX_W'(TOKENS_PER_WORD-1));

    // n = min(zeros_left, room, remaining), kept in 5 bits
    logic [FILL_W-1:0]    room;
    logic [FILL_W-1:0]    n_cap;
    logic [FILL_W-1:0]    n;
    logic [FILL_W-1:0]    w;
    logic [FILL_W-1:0]    fill_d;
    logic [CNT_WIDTH-1:0] remaining_d;
    logic                 emitting;
    logic                 pkt_close;
    logic                 out_free;
    logic                 advance;

    assign room  = FILL_W'(PACKET_SIZE) - fill_q;
    assign n_cap = (remaining_q < CNT_WIDTH'(room)) ? remaining_q[FILL_W-1:0] : room;
    assign n     = (zeros_left_q < {3'b000, n_cap}) ? zeros_left_q[FILL_W-1:0] : n_cap;

    always_comb begin
        w = '0;
        if (state_q == S_ZERO)
            w = n;
        else if (state_q == S_VALUE)
            w = FILL_W'(1);
    end

    assign fill_d      = fill_q + w;
    assign remaining_d = remaining_q - CNT_WIDTH'(w);
    assign emitting    = (state_q == S_ZERO) || (state_q == S_VALUE);
    // A write that completes a packet needs the output register free this edge
    assign pkt_close   = emitting && ((fill_d == FILL_W'(PACKET_SIZE)) || (remaining_d == '0));
    assign out_free    = !out_valid_q || global_buffer_req;
    assign advance     = emitting && !(pkt_close && !out_free);

    // Prefetch on the last token only when the layer is not ending on it
    assign cmp_ready = (state_q == S_LOAD) ||
                       ((state_q == S_VALUE) && last_tok && advance && (remaining_d != '0));

    // Per-slot assembly update and the packet image for the output register
    logic [PACKET_SIZE-1:0][ELEM_WIDTH-1:0] asm_d;
    logic [PACKET_SIZE-1:0][ELEM_WIDTH-1:0] pkt_data_d;
    logic [PACKET_SIZE-1:0]                 mask_d;

    for (genvar gi = 0; gi < PACKET_SIZE; gi++) begin : g_slot
        logic in_range;
        assign in_range       = (FILL_W'(gi) >= fill_q) && (FILL_W'(gi) < fill_d);
        assign asm_d[gi]      = in_range ? ((state_q == S_VALUE) ? cur_val : '0) : asm_q[gi];
        assign mask_d[gi]     = FILL_W'(gi) < fill_d;
        assign pkt_data_d[gi] = mask_d[gi] ? asm_d[gi] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            tok_idx_q    <= '0;
            zeros_left_q <= '0;
            remaining_q  <= '0;
            fill_q       <= '0;
            asm_q        <= '0;
            out_data_q   <= '0;
            out_mask_q   <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else if (start) begin
            word_q       <= '0;
            tok_idx_q    <= '0;
            zeros_left_q <= '0;
            remaining_q  <= total_elements;
            fill_q       <= '0;
            asm_q        <= '0;
            out_data_q   <= '0;
            out_mask_q   <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= (total_elements == '0);
            state_q      <= (total_elements == '0) ? S_DONE : S_LOAD;
        end else begin
            if (out_valid_q && global_buffer_req)
                out_valid_q <= 1'b0;

            case (state_q)
                S_LOAD: begin
                    if (cmp_valid) begin
                        word_q       <= cmp_data;
                        tok_idx_q    <= '0;
                        zeros_left_q <= cmp_data[15:8];
                        state_q      <= (cmp_data[15:8] != 8'd0) ? S_ZERO : S_VALUE;
                    end
                end
                S_ZERO, S_VALUE: begin
                    if (advance) begin
                        asm_q       <= asm_d;
                        remaining_q <= remaining_d;
                        fill_q      <= fill_d;
                        if (pkt_close) begin
                            out_data_q  <= pkt_data_d;
                            out_mask_q  <= mask_d;
                            out_valid_q <= 1'b1;
                            fill_q      <= '0;
                        end
                        if (state_q == S_ZERO) begin
                            zeros_left_q <= zeros_left_q - {3'b000, n};
                            if (zeros_left_q == {3'b000, n})
                                state_q <= S_VALUE;
                        end else if (!last_tok) begin
                            tok_idx_q    <= tok_nx;
                            zeros_left_q <= nxt_run;
                            state_q      <= (nxt_run != 8'd0) ? S_ZERO : S_VALUE;
                        end else if (cmp_valid) begin
                            word_q       <= cmp_data;
                            tok_idx_q    <= '0;
                            zeros_left_q <= cmp_data[15:8];
                            state_q      <= (cmp_data[15:8] != 8'd0) ? S_ZERO : S_VALUE;
                        end else begin
                            state_q <= S_LOAD;
                        end
                        // End of layer overrides any token bookkeeping above
                        if (remaining_d == '0)
                            state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (out_free) begin
                        if (fill_q != '0) begin
                            out_data_q  <= pkt_data_d;
                            out_mask_q  <= mask_d;
                            out_valid_q <= 1'b1;
                            fill_q      <= '0;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign decompressor_ack         = out_valid_q;
    assign decompressed_fifo_packet = {out_data_q, out_mask_q, out_valid_q};
    assign done                     = done_q;

`ifdef DECOMP_PERF_CNT_EN
    logic [31:0] zero_cnt_q;
    logic [31:0] token_cnt_q;
    logic [32:0] zero_sum;

    assign zero_sum = {1'b0, zero_cnt_q} + 33'(n);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            zero_cnt_q  <= '0;
            token_cnt_q <= '0;
        end else if (advance) begin
            if (state_q == S_ZERO)
                zero_cnt_q <= zero_sum[32] ? 32'hFFFF_FFFF : zero_sum[31:0];
            if ((state_q == S_VALUE) && (token_cnt_q != 32'hFFFF_FFFF))
                token_cnt_q <= token_cnt_q + 32'd1;
        end
    end

    assign zero_count  = zero_cnt_q;
    assign token_count = token_cnt_q;
`else
    assign zero_count  = 32'd0;
    assign token_count = 32'd0;
`endif

endmodule

// File: tb/tb_ifmap_decompressor.sv
module tb_ifmap_decompressor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] total_elements;
    logic [63:0] cmp_data;
    logic        cmp_valid;
    logic        cmp_ready;
    logic        global_buffer_req;
    logic        decompressor_ack;
    logic [72:0] decompressed_fifo_packet;
    logic        done;
    logic [31:0] zero_count;
    logic [31:0] token_count;

    ifmap_decompressor dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .total_elements           (total_elements),
        .cmp_data                 (cmp_data),
        .cmp_valid                (cmp_valid),
        .cmp_ready                (cmp_ready),
        .global_buffer_req        (global_buffer_req),
        .decompressor_ack         (decompressor_ack),
        .decompressed_fifo_packet (decompressed_fifo_packet),
        .done                     (done),
        .zero_count               (zero_count),
        .token_count              (token_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] tok_q[$];

    function automatic int expansion();
        int s = 0;
        foreach (tok_q[i]) s += int'(tok_q[i][15:8]) + 1;
        return s;
    endfunction

    function automatic logic [15:0] rand_token();
        logic [7:0] zr;
        zr = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
        if ($urandom_range(0, 9) == 0) zr = 8'($urandom_range(20, 255));
        return {zr, 8'($urandom_range(0, 255))};
    endfunction

    task automatic add_random_tokens(input int total);
        while (expansion() < total) tok_q.push_back(rand_token());
        for (int i = 0; i < 4; i++) tok_q.push_back(rand_token());
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ready"}, cmp_ready, 0);
        check_val({tag, "_ack"}, decompressor_ack, 0);
        check_val({tag, "_pkt"}, decompressed_fifo_packet, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_zc"}, zero_count, 0);
        check_val({tag, "_tc"}, token_count, 0);
    endtask

    // mode: 0 = valid/req always high, 1 = random handshake, 2 = req gap of 5 cycles
    task automatic run_layer(input string name, input int total, input int mode, input bit timing_chk);
        logic [7:0]  elems[$];
        logic [63:0] words[$];
        int exp_zero = 0, exp_tok = 0, n_pkts, pk = 0;
        int acc0 = -1, first_pv = -1, last_xfer = -1, done_cyc = -1;
        bit hold = 0;
        logic [72:0] held_pkt = '0;
        logic [31:0] ezc, etc;

        // Reference: expand tokens into the element stream, truncated at total
        foreach (tok_q[t]) begin
            for (int r = 0; r < int'(tok_q[t][15:8]) && elems.size() < total; r++) begin
                elems.push_back(8'h00);
                exp_zero++;
            end
            if (elems.size() < total) begin
                elems.push_back(tok_q[t][7:0]);
                exp_tok++;
            end
        end
        while (tok_q.size() % 4 != 0) tok_q.push_back(rand_token());
        for (int i = 0; i < tok_q.size(); i += 4)
            words.push_back({tok_q[i+3], tok_q[i+2], tok_q[i+1], tok_q[i]});
        tok_q.delete();
        n_pkts = (total + 7) / 8;

        @(negedge clk);
        start = 1'b1; total_elements = 20'(total); cmp_valid = 1'b0; global_buffer_req = 1'b0;
        @(negedge clk);
        start = 1'b0;

        for (int cyc = 0; cyc < 5000; cyc++) begin
            cmp_valid = (words.size() > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
            cmp_data  = (words.size() > 0) ? words[0] : 64'($urandom);
            global_buffer_req = (mode == 1) ? ($urandom_range(0, 2) != 0) :
                                (mode == 2) ? !(cyc >= 10 && cyc < 15) : 1'b1;
            #1;
            if (hold) check_val("stable", decompressed_fifo_packet, held_pkt);
            check_val("ack_eq_valid", decompressor_ack, decompressed_fifo_packet[0]);
            if (decompressed_fifo_packet[0] && first_pv < 0) first_pv = cyc;
            if (cmp_valid && cmp_ready) begin
                if (acc0 < 0) acc0 = cyc;
                void'(words.pop_front());
            end
            if (decompressed_fifo_packet[0] && global_buffer_req) begin
                logic [63:0] ed = '0;
                logic [7:0]  em = '0;
                for (int s = 0; s < 8; s++)
                    if (pk * 8 + s < total) begin
                        ed[8*s +: 8] = elems[pk*8 + s];
                        em[s] = 1'b1;
                    end
                $display("%s: pkt %0d data=%h mask=%h", name, pk, decompressed_fifo_packet[72:9],
                         decompressed_fifo_packet[8:1]);
                check_val("pkt_index", pk < n_pkts, 1);
                check_val("pkt_data", decompressed_fifo_packet[72:9], ed);
                check_val("pkt_mask", decompressed_fifo_packet[8:1], em);
                pk++;
                last_xfer = cyc;
            end
            hold     = decompressed_fifo_packet[0] && !global_buffer_req;
            held_pkt = decompressed_fifo_packet;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end

        check_val("done_seen", done_cyc >= 0, 1);
        check_val("pkt_count", pk, n_pkts);
        check_val("done_after_xfer", done_cyc, last_xfer + 1);
        if (timing_chk) begin
            check_val("word0_cycle", acc0, 0);
            check_val("pv_rise_cycle", first_pv, 9);
        end
`ifdef DECOMP_PERF_CNT_EN
        ezc = 32'(exp_zero); etc = 32'(exp_tok);
`else
        ezc = 0; etc = 0;
`endif
        check_val("zero_count", zero_count, ezc);
        check_val("token_count", token_count, etc);
        // After the layer: words offered must be refused and done must hold
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_valid = 1'b1; cmp_data = 64'($urandom); global_buffer_req = 1'b1;
            #1;
            check_val("post_ready", cmp_ready, 0);
            check_val("post_valid", decompressed_fifo_packet[0], 0);
            check_val("post_done", done, 1);
        end
        $display("%s: total=%0d packets=%0d zeros=%0d tokens=%0d", name, total, pk, exp_zero, exp_tok);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; total_elements = '0; cmp_data = '0;
        cmp_valid = 1'b0; global_buffer_req = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Dense word pair, checks word/packet timing
        tok_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088};
        run_layer("dense8", 8, 0, 1'b1);

        // Single long run split across three packets
        tok_q = '{16'h147F, 16'h0001, 16'h0002, 16'h0003};
        run_layer("run20", 21, 0, 1'b0);

        // Layer ends inside a zero run
        tok_q = '{16'h0C01, 16'h0302, 16'h0003, 16'h0504};
        run_layer("trunc10", 10, 0, 1'b0);

        // Consumer stalls for five cycles with packets pending
        add_random_tokens(40);
        run_layer("req_gap", 40, 2, 1'b0);

        // Randomized layers
        for (int l = 0; l < 8; l++) begin
            int tot = (l == 0) ? 1 : $urandom_range(1, 120);
            add_random_tokens(tot);
            run_layer($sformatf("rand%0d", l), tot, 1, 1'b0);
        end

        // Empty layer
        run_layer("empty", 0, 1, 1'b0);

        // start with total 0 mid-layer drops everything
        @(negedge clk);
        start = 1'b1; total_elements = 20'd50; global_buffer_req = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cmp_valid = 1'b1; cmp_data = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
            @(negedge clk);
        end
        check_val("abort_pending_pkt", decompressed_fifo_packet[0], 1);
        start = 1'b1; total_elements = 20'd0;
        @(negedge clk);
        start = 1'b0; cmp_valid = 1'b0;
        #1;
        check_val("abort_done", done, 1);
        check_val("abort_pkt", decompressed_fifo_packet, 0);
        check_val("abort_ack", decompressor_ack, 0);
        check_val("abort_ready", cmp_ready, 0);
        check_val("abort_zc", zero_count, 0);
        check_val("abort_tc", token_count, 0);
        $display("abort: done=%0d pkt_valid=%0d", done, decompressed_fifo_packet[0]);

        // rst together with start: reset wins, FSM idles
        @(negedge clk);
        rst = 1'b1; start = 1'b1; total_elements = 20'd5; cmp_valid = 1'b1;
        @(negedge clk);
        #1 check_all_zero("rst_start");
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("idle_ready", cmp_ready, 0);
        check_val("idle_done", done, 0);
        check_val("idle_valid", decompressed_fifo_packet[0], 0);
        $display("rst_start: done=%0d ready=%0d", done, cmp_ready);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
